// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  localparam int INSTR_W = 32;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
// Module   : imem_loader_byte_packer
// Purpose  : Packs accepted bytes big-endian into 32-bit instruction words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               accept,
  input  logic [BYTE_W-1:0]  in_byte,
  output logic [1:0]         byte_idx,
  output logic [INSTR_W-1:0] word,
  output logic               word_ready
);

  // First three bytes of the word in arrival order; the fourth is taken
  // straight from the input so the word can be committed on its accept edge.
  logic [INSTR_W-BYTE_W-1:0] held_bytes;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx   <= 2'd0;
      held_bytes <= '0;
    end else if (clear) begin
      byte_idx   <= 2'd0;
    end else if (accept) begin
      byte_idx   <= byte_idx + 2'd1;
      held_bytes <= {held_bytes[INSTR_W-2*BYTE_W-1:0], in_byte};
    end
  end

  assign word       = {held_bytes, in_byte};
  assign word_ready = accept && (byte_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time byte-stream loader for the MIPS instruction memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BYTE_W-1:0]  in_byte,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               pipe_run,
  output logic [ADDR_W:0]    word_count,
  output logic               load_err
);

  localparam logic [ADDR_W:0] DEPTH_LAST = (ADDR_W+1)'(DEPTH_WORDS - 1);

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic [1:0]         byte_idx;
  logic [INSTR_W-1:0] word;
  logic               word_ready;

  assign in_ready = (state == LOAD) && !start;
  assign accept   = in_valid && in_ready;
  assign load_err = (state == ERR);

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start),
    .accept     (accept),
    .in_byte    (in_byte),
    .byte_idx   (byte_idx),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (word_ready) begin
          if (in_last)
            state_next = FLUSH;
          else if (word_count == DEPTH_LAST)
            state_next = ERR;
        end else if (accept && in_last) begin
          // Last byte arrived mid-word: the partial word is never written.
          state_next = ERR;
        end
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = LOAD;
    endcase
    if (start)
      state_next = LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      pipe_run   <= 1'b0;
    end else begin
      state   <= state_next;
      imem_we <= word_ready;
      if (word_ready) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= word;
        word_count <= word_count + (ADDR_W+1)'(1);
      end
      if (start)
        word_count <= '0;
      // Registered from DONE so fetch never overlaps the final write cycle.
      pipe_run <= (state == DONE) && !start;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle table for the nominal load plus
// hand-written sequences for restart, stall, error and reset corner cases.
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;

  logic        in_ready, imem_we, pipe_run, load_err;
  logic [6:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [7:0]  word_count;

  logic        ready2, we2, run2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  wc2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader #(.DEPTH_WORDS(128), .ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pipe_run(pipe_run), .word_count(word_count), .load_err(load_err)
  );

  imem_loader #(.DEPTH_WORDS(4), .ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte),
    .in_valid(in_valid), .in_last(in_last), .in_ready(ready2),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .pipe_run(run2), .word_count(wc2), .load_err(err2)
  );

  // Write and release monitor
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          w2_addr[$];
  logic [31:0] w2_data[$];
  int          rise_cyc = -1;
  logic        pipe_prev = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (we2) begin
      w2_addr.push_back(int'(addr2));
      w2_data.push_back(wdata2);
    end
    if (pipe_run && !pipe_prev) rise_cyc = cyc;
    pipe_prev = pipe_run;
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    w2_addr.delete(); w2_data.delete();
    rise_cyc = -1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle_in(input logic s, input logic v, input logic [7:0] b, input logic l);
    @(posedge clk);
    #1;
    start = s; in_valid = v; in_byte = b; in_last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_in(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] stream [32];

  task automatic send_stream(input int n, input bit last, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      cycle_in(1'b0, 1'b1, stream[i], last && (i == n - 1));
      if (i == gap_at) idle(gap_len);
    end
    idle(1);
  endtask

  task automatic set_prog8();
    stream[0] = 8'h20; stream[1] = 8'h08; stream[2] = 8'h00; stream[3] = 8'h05;
    stream[4] = 8'h01; stream[5] = 8'h09; stream[6] = 8'h50; stream[7] = 8'h20;
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  b;
    logic        l;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic        run;
    logic        rdy;
    logic [7:0]  wc;
    logic        err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int s;

    //           st  v   b      l   we  addr  wdata         run rdy wc err
    tbl[0]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,7'd0,32'h00000000,1'b0,1'b1,8'd0,1'b0};
    tbl[1]  = '{1'b0,1'b1,8'h20,1'b0,1'b0,7'd0,32'h00000000,1'b0,1'b1,8'd0,1'b0};
    tbl[2]  = '{1'b0,1'b1,8'h08,1'b0,1'b0,7'd0,32'h00000000,1'b0,1'b1,8'd0,1'b0};
    tbl[3]  = '{1'b0,1'b1,8'h00,1'b0,1'b0,7'd0,32'h00000000,1'b0,1'b1,8'd0,1'b0};
    tbl[4]  = '{1'b0,1'b1,8'h05,1'b0,1'b0,7'd0,32'h00000000,1'b0,1'b1,8'd0,1'b0};
    tbl[5]  = '{1'b0,1'b1,8'h01,1'b0,1'b1,7'd0,32'h20080005,1'b0,1'b1,8'd1,1'b0};
    tbl[6]  = '{1'b0,1'b1,8'h09,1'b0,1'b0,7'd0,32'h20080005,1'b0,1'b1,8'd1,1'b0};
    tbl[7]  = '{1'b0,1'b1,8'h50,1'b0,1'b0,7'd0,32'h20080005,1'b0,1'b1,8'd1,1'b0};
    tbl[8]  = '{1'b0,1'b1,8'h20,1'b1,1'b0,7'd0,32'h20080005,1'b0,1'b1,8'd1,1'b0};
    tbl[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,7'd1,32'h01095020,1'b0,1'b0,8'd2,1'b0};
    tbl[10] = '{1'b0,1'b0,8'h00,1'b0,1'b0,7'd1,32'h01095020,1'b0,1'b0,8'd2,1'b0};
    tbl[11] = '{1'b0,1'b0,8'h00,1'b0,1'b0,7'd1,32'h01095020,1'b1,1'b0,8'd2,1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal 8-byte load, one byte per cycle, checked cycle by cycle
    for (int i = 0; i < 12; i++) begin
      cycle_in(tbl[i].st, tbl[i].v, tbl[i].b, tbl[i].l);
      @(negedge clk);
      chk($sformatf("row%0d we", i),    {31'd0, imem_we},   {31'd0, tbl[i].we});
      chk($sformatf("row%0d addr", i),  {25'd0, imem_addr}, {25'd0, tbl[i].addr});
      chk($sformatf("row%0d wdata", i), imem_wdata,         tbl[i].wd);
      chk($sformatf("row%0d run", i),   {31'd0, pipe_run},  {31'd0, tbl[i].run});
      chk($sformatf("row%0d ready", i), {31'd0, in_ready},  {31'd0, tbl[i].rdy});
      chk($sformatf("row%0d wc", i),    {24'd0, word_count},{24'd0, tbl[i].wc});
      chk($sformatf("row%0d err", i),   {31'd0, load_err},  {31'd0, tbl[i].err});
    end

    // Restart from DONE with a byte offered in the start cycle
    clear_log();
    cycle_in(1'b1, 1'b1, 8'hEE, 1'b0);
    @(negedge clk);
    chk("start_ready", {31'd0, in_ready}, 32'd0);
    idle(1);
    @(negedge clk);
    chk("restart_run", {31'd0, pipe_run}, 32'd0);
    chk("restart_wc", {24'd0, word_count}, 32'd0);
    chk("restart_ready", {31'd0, in_ready}, 32'd1);
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
    send_stream(4, 1'b1, -1, 0);
    idle(5);
    chk("restart_nwr", wr_addr.size(), 32'd1);
    chk("restart_addr", (wr_addr.size() > 0) ? wr_addr[0] : -1, 32'd0);
    chk("restart_data", (wr_data.size() > 0) ? wr_data[0] : 32'hDEADDEAD, 32'h11223344);
    chk("restart_done_run", {31'd0, pipe_run}, 32'd1);
    chk("restart_done_wc", {24'd0, word_count}, 32'd1);

    // Same 8-byte program with a 3-cycle stall between bytes 2 and 3
    clear_log();
    set_prog8();
    cycle_in(1'b1, 1'b0, 8'h00, 1'b0);
    s = cyc;
    send_stream(8, 1'b1, 1, 3);
    idle(8);
    chk("stall_nwr", wr_addr.size(), 32'd2);
    chk("stall_addr0", (wr_addr.size() > 0) ? wr_addr[0] : -1, 32'd0);
    chk("stall_data0", (wr_data.size() > 0) ? wr_data[0] : 32'hDEADDEAD, 32'h20080005);
    chk("stall_addr1", (wr_addr.size() > 1) ? wr_addr[1] : -1, 32'd1);
    chk("stall_data1", (wr_data.size() > 1) ? wr_data[1] : 32'hDEADDEAD, 32'h01095020);
    chk("stall_cyc0", (wr_cyc.size() > 0) ? wr_cyc[0] - s : -1, 32'd8);
    chk("stall_cyc1", (wr_cyc.size() > 1) ? wr_cyc[1] - s : -1, 32'd12);
    chk("stall_rise", rise_cyc - s, 32'd14);
    chk("stall_wc", {24'd0, word_count}, 32'd2);
    chk("stall_err", {31'd0, load_err}, 32'd0);

    // Partial final word: 6 bytes with in_last on the sixth
    clear_log();
    cycle_in(1'b1, 1'b0, 8'h00, 1'b0);
    send_stream(6, 1'b1, -1, 0);
    idle(4);
    chk("part_nwr", wr_addr.size(), 32'd1);
    chk("part_data0", (wr_data.size() > 0) ? wr_data[0] : 32'hDEADDEAD, 32'h20080005);
    chk("part_err", {31'd0, load_err}, 32'd1);
    chk("part_run", {31'd0, pipe_run}, 32'd0);
    chk("part_ready", {31'd0, in_ready}, 32'd0);
    chk("part_wc", {24'd0, word_count}, 32'd1);

    // Overflow on the 4-word instance: 20 bytes, no in_last
    clear_log();
    cycle_in(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle_in(1'b0, 1'b1, 8'(i), 1'b0);
      @(negedge clk);
      if (i == 15) chk("ovf_ready16", {31'd0, ready2}, 32'd1);
      if (i == 16) chk("ovf_ready17", {31'd0, ready2}, 32'd0);
    end
    idle(3);
    chk("ovf_nwr", w2_addr.size(), 32'd4);
    for (int w = 0; w < 4; w++) begin
      logic [31:0] exp_w;
      exp_w = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
      chk($sformatf("ovf_addr%0d", w), (w2_addr.size() > w) ? w2_addr[w] : -1, 32'(w));
      chk($sformatf("ovf_data%0d", w), (w2_data.size() > w) ? w2_data[w] : 32'hDEADDEAD, exp_w);
    end
    chk("ovf_err", {31'd0, err2}, 32'd1);
    chk("ovf_run", {31'd0, run2}, 32'd0);
    chk("ovf_wc", {29'd0, wc2}, 32'd4);

    // Reset after two bytes of a word, then a clean 4-byte reload
    cycle_in(1'b1, 1'b0, 8'h00, 1'b0);
    stream[0] = 8'h11; stream[1] = 8'h22;
    for (int i = 0; i < 2; i++) cycle_in(1'b0, 1'b1, stream[i], 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
    @(negedge clk);
    chk("rst_wc", {24'd0, word_count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    stream[0] = 8'hAA; stream[1] = 8'hBB; stream[2] = 8'hCC; stream[3] = 8'hDD;
    send_stream(4, 1'b1, -1, 0);
    idle(5);
    chk("rst_nwr", wr_addr.size(), 32'd1);
    chk("rst_addr", (wr_addr.size() > 0) ? wr_addr[0] : -1, 32'd0);
    chk("rst_data", (wr_data.size() > 0) ? wr_data[0] : 32'hDEADDEAD, 32'hAABBCCDD);
    chk("rst_run", {31'd0, pipe_run}, 32'd1);
    chk("rst_err", {31'd0, load_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
